// File: rtl/cpu_fetch_pkg.sv
// Shared fetch-stage types and widths for the 8-bit CPU; decode and the ALU bench use
// the same pc_t/instr_t so that the buses line up without casts.
package cpu_fetch_pkg;

  localparam int PC_W    = 8;
  localparam int INSTR_W = 16;
  localparam logic [PC_W-1:0] RESET_PC = 8'h00;

  typedef logic [PC_W-1:0]    pc_t;
  typedef logic [INSTR_W-1:0] instr_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_pc_gen.sv
// Next-pc select for the fetch stage: branch redirect, sequential advance (wrapping),
// or hold. Purely combinational; the pc register lives in fetch_pc_unit.
module fetch_pc_gen
  import cpu_fetch_pkg::*;
#(
  parameter int PC_W = cpu_fetch_pkg::PC_W
) (
  input  logic [PC_W-1:0] pc,
  input  logic            redirect,
  input  logic            advance,
  input  logic [PC_W-1:0] branch_target,
  output logic [PC_W-1:0] pc_next
);

  // Redirect wins over advance; the increment wraps at 2^PC_W with no carry out.
  always_comb begin
    pc_next = pc;
    if (redirect) begin
      pc_next = branch_target;
    end else if (advance) begin
      pc_next = pc + PC_W'(1);
    end
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// Instruction-fetch stage: owns the pc, keeps one memory request in flight at a time,
// buffers one fetched instruction for decode, and honours ALU branch redirects.
module fetch_pc_unit
  import cpu_fetch_pkg::*;
#(
  parameter int              PC_W     = cpu_fetch_pkg::PC_W,
  parameter int              INSTR_W  = cpu_fetch_pkg::INSTR_W,
  parameter logic [PC_W-1:0] RESET_PC = cpu_fetch_pkg::RESET_PC
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [PC_W-1:0]    imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  input  logic               ex_valid,
  input  logic               B_PCSrc,
  input  logic [PC_W-1:0]    branch_target,
  input  logic               id_stall,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [PC_W-1:0]    if_pc
);

  fetch_state_e    state;
  fetch_state_e    state_next;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] pc_next;
  logic            drop;
  logic            drop_next;
  logic            redirect;
  logic            accept;
  logic            capture;
  logic            consume;

  assign redirect      = ex_valid && B_PCSrc;
  assign accept        = (state == REQ) && imem_req_ready;
  assign capture       = (state == WAIT) && imem_rsp_valid && !drop && !redirect;
  assign consume       = (state == HOLD) && !id_stall;
  assign imem_req_addr = pc;

  fetch_pc_gen #(
    .PC_W(PC_W)
  ) u_pc_gen (
    .pc            (pc),
    .redirect      (redirect),
    .advance       (capture),
    .branch_target (branch_target),
    .pc_next       (pc_next)
  );

  // drop marks a request that was overtaken by a redirect; its response must be discarded.
  always_comb begin
    state_next = state;
    drop_next  = drop;
    case (state)
      IDLE: state_next = REQ;
      REQ: begin
        if (accept) begin
          state_next = WAIT;
          drop_next  = redirect;
        end
      end
      WAIT: begin
        if (imem_rsp_valid) begin
          state_next = capture ? HOLD : REQ;
          drop_next  = 1'b0;
        end else if (redirect) begin
          drop_next = 1'b1;
        end
      end
      HOLD: begin
        if (redirect || !id_stall) begin
          state_next = REQ;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      pc             <= RESET_PC;
      drop           <= 1'b0;
      imem_req_valid <= 1'b0;
      if_valid       <= 1'b0;
      if_instr       <= '0;
      if_pc          <= '0;
    end else begin
      state          <= state_next;
      pc             <= pc_next;
      drop           <= drop_next;
      imem_req_valid <= (state_next == REQ);
      if (redirect || consume) begin
        if_valid <= 1'b0;
      end else if (capture) begin
        if_valid <= 1'b1;
      end
      if (capture) begin
        if_instr <= imem_rsp_data;
        if_pc    <= pc;
      end
    end
  end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: a per-cycle vector table, hand-written redirect/wrap/reset
// sequences, then randomized traffic checked against a transaction-level model.
module tb_fetch_pc_unit;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [7:0]  imem_req_addr;
  logic        imem_rsp_valid;
  logic [15:0] imem_rsp_data;
  logic        ex_valid;
  logic        B_PCSrc;
  logic [7:0]  branch_target;
  logic        id_stall;
  logic        if_valid;
  logic [15:0] if_instr;
  logic [7:0]  if_pc;

  int n_vec  = 0;
  int n_miss = 0;

  fetch_pc_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .ex_valid       (ex_valid),
    .B_PCSrc        (B_PCSrc),
    .branch_target  (branch_target),
    .id_stall       (id_stall),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ready;
    logic        rsp_valid;
    logic [15:0] rsp_data;
    logic        stall;
    logic        exp_req_valid;
    logic [7:0]  exp_addr;
    logic        exp_if_valid;
    logic [7:0]  exp_if_pc;
    logic [15:0] exp_if_instr;
  } vec_t;

  vec_t tbl [15];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One clean fetch from REQ back to REQ with zero wait states and no stall.
  task automatic fetch_one(input logic [7:0] addr);
    logic [15:0] data;
    data = 16'hA000 + {8'h00, addr};
    check_output("fetch_req_valid", imem_req_valid, 1);
    check_output("fetch_req_addr", imem_req_addr, addr);
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = data;
    tick();
    imem_rsp_valid = 1'b0;
    check_output("fetch_if_valid", if_valid, 1);
    check_output("fetch_if_pc", if_pc, addr);
    check_output("fetch_if_instr", if_instr, data);
    tick();
  endtask

  logic [7:0]  model_pc;
  logic [7:0]  acc_addr;
  logic [7:0]  exp_pc;
  logic [15:0] exp_instr;
  logic        outstanding;
  logic        stale;
  logic        exp_ifv;
  logic        redirect_now;
  logic        deliver;
  int          countdown;
  int          deliveries;

  initial begin
    rst_n          = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    ex_valid       = 1'b0;
    B_PCSrc        = 1'b0;
    branch_target  = '0;
    id_stall       = 1'b0;

    // ready=1, 1-cycle memory, then a 5-cycle stall while holding 02
    tbl[0]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00, 16'h0000};
    tbl[1]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 16'h0000};
    tbl[2]  = '{1'b1, 1'b1, 16'hA000, 1'b0, 1'b0, 8'h01, 1'b1, 8'h00, 16'hA000};
    tbl[3]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 8'h01, 1'b0, 8'h00, 16'h0000};
    tbl[4]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 8'h01, 1'b0, 8'h00, 16'h0000};
    tbl[5]  = '{1'b1, 1'b1, 16'hA001, 1'b0, 1'b0, 8'h02, 1'b1, 8'h01, 16'hA001};
    tbl[6]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 8'h02, 1'b0, 8'h00, 16'h0000};
    tbl[7]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 8'h02, 1'b0, 8'h00, 16'h0000};
    tbl[8]  = '{1'b1, 1'b1, 16'hA002, 1'b0, 1'b0, 8'h03, 1'b1, 8'h02, 16'hA002};
    for (int i = 9; i < 14; i++) begin
      tbl[i] = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 8'h03, 1'b1, 8'h02, 16'hA002};
    end
    tbl[14] = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 8'h03, 1'b0, 8'h00, 16'h0000};

    repeat (2) tick();
    check_output("reset_req_valid", imem_req_valid, 0);
    check_output("reset_req_addr", imem_req_addr, 8'h00);
    check_output("reset_if_valid", if_valid, 0);
    check_output("reset_if_pc", if_pc, 0);
    check_output("reset_if_instr", if_instr, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      imem_req_ready = tbl[i].ready;
      imem_rsp_valid = tbl[i].rsp_valid;
      imem_rsp_data  = tbl[i].rsp_data;
      id_stall       = tbl[i].stall;
      tick();
      check_output($sformatf("tbl%0d_req_valid", i), imem_req_valid, tbl[i].exp_req_valid);
      check_output($sformatf("tbl%0d_req_addr", i), imem_req_addr, tbl[i].exp_addr);
      check_output($sformatf("tbl%0d_if_valid", i), if_valid, tbl[i].exp_if_valid);
      if (tbl[i].exp_if_valid) begin
        check_output($sformatf("tbl%0d_if_pc", i), if_pc, tbl[i].exp_if_pc);
        check_output($sformatf("tbl%0d_if_instr", i), if_instr, tbl[i].exp_if_instr);
      end
    end
    imem_rsp_valid = 1'b0;
    id_stall       = 1'b0;

    // redirect while waiting, response two cycles later is dropped
    tick();
    imem_req_ready = 1'b0;
    check_output("wait_req_valid", imem_req_valid, 0);
    ex_valid = 1'b1; B_PCSrc = 1'b1; branch_target = 8'h40;
    tick();
    ex_valid = 1'b0; B_PCSrc = 1'b0;
    check_output("wait_redir_addr", imem_req_addr, 8'h40);
    check_output("wait_redir_if_valid", if_valid, 0);
    tick();
    imem_rsp_valid = 1'b1; imem_rsp_data = 16'hA003;
    tick();
    imem_rsp_valid = 1'b0;
    check_output("wait_drop_if_valid", if_valid, 0);
    check_output("wait_drop_req_valid", imem_req_valid, 1);
    check_output("wait_drop_addr", imem_req_addr, 8'h40);

    // redirect coinciding with the response
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1; imem_rsp_data = 16'hA040;
    ex_valid = 1'b1; B_PCSrc = 1'b1; branch_target = 8'h80;
    tick();
    imem_rsp_valid = 1'b0; ex_valid = 1'b0; B_PCSrc = 1'b0;
    check_output("samecyc_if_valid", if_valid, 0);
    check_output("samecyc_req_valid", imem_req_valid, 1);
    check_output("samecyc_addr", imem_req_addr, 8'h80);

    // redirect flushes a stalled buffered instruction
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1; imem_rsp_data = 16'hA080;
    tick();
    imem_rsp_valid = 1'b0;
    check_output("hold_if_valid", if_valid, 1);
    check_output("hold_if_pc", if_pc, 8'h80);
    check_output("hold_if_instr", if_instr, 16'hA080);
    id_stall = 1'b1;
    tick();
    check_output("hold_stall_if_valid", if_valid, 1);
    ex_valid = 1'b1; B_PCSrc = 1'b1; branch_target = 8'hC0;
    tick();
    ex_valid = 1'b0; B_PCSrc = 1'b0; id_stall = 1'b0;
    check_output("flush_if_valid", if_valid, 0);
    check_output("flush_req_valid", imem_req_valid, 1);
    check_output("flush_addr", imem_req_addr, 8'hC0);

    // B_PCSrc without ex_valid must be ignored
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1; imem_rsp_data = 16'hA0C0;
    B_PCSrc = 1'b1; branch_target = 8'h10;
    tick();
    imem_rsp_valid = 1'b0;
    check_output("noex_if_valid", if_valid, 1);
    check_output("noex_if_pc", if_pc, 8'hC0);
    check_output("noex_addr", imem_req_addr, 8'hC1);
    tick();
    B_PCSrc = 1'b0;
    check_output("noex_req_valid", imem_req_valid, 1);
    check_output("noex_next_addr", imem_req_addr, 8'hC1);

    // retarget an unaccepted request to FE, then fetch across the wrap
    ex_valid = 1'b1; B_PCSrc = 1'b1; branch_target = 8'hFE;
    tick();
    ex_valid = 1'b0; B_PCSrc = 1'b0;
    check_output("retarget_req_valid", imem_req_valid, 1);
    check_output("retarget_addr", imem_req_addr, 8'hFE);
    fetch_one(8'hFE);
    fetch_one(8'hFF);
    fetch_one(8'h00);

    // reset in WAIT; a late response after release is ignored
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    check_output("async_rst_req_valid", imem_req_valid, 0);
    check_output("async_rst_if_valid", if_valid, 0);
    check_output("async_rst_addr", imem_req_addr, 8'h00);
    tick();
    rst_n = 1'b1;
    imem_rsp_valid = 1'b1; imem_rsp_data = 16'hBEEF;
    tick();
    imem_rsp_valid = 1'b0;
    check_output("post_rst_if_valid", if_valid, 0);
    check_output("post_rst_req_valid", imem_req_valid, 1);
    check_output("post_rst_addr", imem_req_addr, 8'h00);
    fetch_one(8'h00);

    // randomized traffic against a transaction-level model
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    model_pc = 8'h00; outstanding = 1'b0; stale = 1'b0; exp_ifv = 1'b0;
    exp_pc = '0; exp_instr = '0; acc_addr = '0; countdown = 0; deliveries = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      check_output("rnd_if_valid", if_valid, exp_ifv);
      if (exp_ifv) begin
        check_output("rnd_if_pc", if_pc, exp_pc);
        check_output("rnd_if_instr", if_instr, exp_instr);
        check_output("rnd_no_req_while_valid", imem_req_valid, 0);
      end

      imem_req_ready = ($urandom_range(0, 2) != 0);
      id_stall       = ($urandom_range(0, 2) == 0);
      ex_valid       = ($urandom_range(0, 7) == 0);
      B_PCSrc        = 1'($urandom_range(0, 1));
      branch_target  = 8'($urandom);
      if (outstanding && countdown == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = {acc_addr, ~acc_addr};
      end else begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 16'($urandom);
      end
      redirect_now = ex_valid && B_PCSrc;
      deliver      = 1'b0;

      if (imem_req_valid && imem_req_ready) begin
        check_output("rnd_req_addr", imem_req_addr, model_pc);
        check_output("rnd_one_outstanding", outstanding, 0);
        outstanding = 1'b1;
        acc_addr    = imem_req_addr;
        stale       = redirect_now;
        countdown   = int'($urandom_range(0, 2));
      end else if (outstanding) begin
        if (imem_rsp_valid) begin
          deliver     = !stale && !redirect_now;
          outstanding = 1'b0;
        end else begin
          if (redirect_now) stale = 1'b1;
          if (countdown > 0) countdown--;
        end
      end

      if (redirect_now)      exp_ifv = 1'b0;
      else if (deliver)      exp_ifv = 1'b1;
      else                   exp_ifv = exp_ifv && id_stall;
      if (deliver) begin
        exp_pc    = acc_addr;
        exp_instr = {acc_addr, ~acc_addr};
        model_pc  = acc_addr + 8'd1;
        deliveries++;
      end
      if (redirect_now) model_pc = branch_target;
      tick();
    end
    check_output("rnd_if_valid_final", if_valid, exp_ifv);
    check_output("rnd_progress", (deliveries > 100), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
